fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter BIT_WIDTH, default 32, meaning instruction width in bits.
REQ-002 The block SHALL have parameter ENTRY_COUNT, default 256, meaning instruction memory depth in words.
REQ-003 The block SHALL have parameter ADDR_WIDTH, default $clog2((BIT_WIDTH/8)*ENTRY_COUNT), meaning byte-address width.
REQ-004 The block SHALL have parameter RESET_PC, default 0, meaning the first fetch byte address.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port imem_addr, output, ADDR_WIDTH bits: byte address to instruction memory.
REQ-008 The block SHALL have port imem_data, input, BIT_WIDTH bits: combinational read data for imem_addr.
REQ-009 The block SHALL have port redirect_valid, input, 1 bit: branch/jump redirect request.
REQ-010 The block SHALL have port redirect_pc, input, ADDR_WIDTH bits: redirect target byte address.
REQ-011 The block SHALL have port out_valid, output, 1 bit: out_instr/out_pc hold a valid fetched instruction.
REQ-012 The block SHALL have port out_ready, input, 1 bit: decode accepts the instruction this cycle.
REQ-013 The block SHALL have port out_instr, output, BIT_WIDTH bits: fetched instruction.
REQ-014 The block SHALL have port out_pc, output, ADDR_WIDTH bits: byte address of out_instr.
REQ-015 The block SHALL have port fault, output, 1 bit: misaligned redirect detected; fetch stopped.
REQ-016 The block SHALL have port fetch_count, output, 32 bits: instructions handed off (out_valid && out_ready).

Function
REQ-017 The block SHALL keep a PC register and drive imem_addr = pc combinationally at all times.
REQ-018 The block SHALL implement states BOOT, RUN, FAULT; BOOT lasts exactly one cycle after reset release, then RUN.
REQ-019 In BOOT, the block SHALL not load the output register and SHALL keep pc = RESET_PC.
REQ-020 In RUN, the block SHALL define "advance" as out_valid==0 or out_ready==1.
REQ-021 On advance without redirect, the block SHALL load out_instr<=imem_data, out_pc<=pc, out_valid<=1, pc<=pc+4 (one-cycle latency from address to output).
REQ-022 When out_valid==1 and out_ready==0, the block SHALL hold out_instr, out_pc, out_valid and pc unchanged.
REQ-023 On aligned redirect_valid (redirect_pc[1:0]==0) in RUN, the block SHALL set pc<=redirect_pc and out_valid<=0 regardless of out_ready; redirect has priority over advance and stall.
REQ-024 On redirect_valid with redirect_pc[1:0]!=0, the block SHALL enter FAULT, set fault<=1, out_valid<=0, and freeze pc.
REQ-025 FAULT SHALL be terminal until rst_n is asserted; redirect_valid and out_ready are ignored there.
REQ-026 The block SHALL compute pc+4 modulo 2^ADDR_WIDTH (wrap to 0 past the last word), with no fault on wrap.
REQ-027 The block SHALL increment fetch_count by 1 on every cycle with out_valid && out_ready, including the redirect cycle, wrapping at 2^32.
REQ-028 The block SHALL ignore redirect_valid in BOOT.

Reset
REQ-029 While rst_n==0, the block SHALL force state=BOOT, pc=RESET_PC, out_valid=0, out_instr=0, out_pc=0, fault=0, fetch_count=0, asynchronously.
REQ-030 If reset is asserted mid-stall or mid-redirect, the block SHALL discard the pending instruction and resume per REQ-018.

Structure
REQ-031 The state enum and the PC_STEP=4 constant SHALL live in shared package fetch_pkg.
REQ-032 The output valid/ready holding register SHALL be one sub-module, fetch_out_reg, with load, hold and flush controls.

Verification
REQ-033 Reset release, out_ready=1, memory words 0x11,0x22,0x33 -> out_valid rises on the 2nd edge after release; out_pc 0x0,0x4,0x8 carry 0x11,0x22,0x33 on consecutive cycles.
REQ-034 out_valid=1, out_pc=0x4, out_ready held 0 for 3 cycles -> out_pc/out_instr stable at 0x4/0x22, pc stays 0x8, fetch_count unchanged.
REQ-035 redirect_valid=1, redirect_pc=0x40 while stalled -> next cycle out_valid=0; following cycle out_pc=0x40 with mem[0x40>>2].
REQ-036 redirect_pc=0x42 -> fault=1 and out_valid=0 next cycle; both hold for 10 cycles despite redirect to 0x0; rst_n pulse clears fault.
REQ-037 ENTRY_COUNT=4, free-run -> out_pc sequence 0x0,0x4,0x8,0xC,0x0; fetch_count=5 after five handshakes.
REQ-038 rst_n asserted asynchronously mid-cycle while stalled -> out_valid drops to 0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit.
//   fetch_state_e : fetch control states (boot, run, fault)
//   PC_STEP       : byte increment between sequential instruction words
package fetch_pkg;

    typedef enum logic [1:0] {
        StBoot  = 2'd0,
        StRun   = 2'd1,
        StFault = 2'd2
    } fetch_state_e;

    localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/fetch_out_reg.sv
// Valid/ready holding register presented to decode.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   load                : capture in_instr/in_pc and set valid
//   hold                : keep current contents (blocks load)
//   flush               : clear valid; wins over load and hold
//   in_instr, in_pc     : data to capture
//   valid, instr, pc    : registered outputs
module fetch_out_reg #(
    parameter int unsigned BIT_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  hold,
    input  logic                  flush,
    input  logic [BIT_WIDTH-1:0]  in_instr,
    input  logic [ADDR_WIDTH-1:0] in_pc,
    output logic                  valid,
    output logic [BIT_WIDTH-1:0]  instr,
    output logic [ADDR_WIDTH-1:0] pc
);

    logic                  valid_q, valid_d;
    logic [BIT_WIDTH-1:0]  instr_q, instr_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;

    // Flush only drops valid; stale data behind valid=0 is harmless.
    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load && !hold) begin
            valid_d = 1'b1;
            instr_d = in_instr;
            pc_d    = in_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign valid = valid_q;
    assign instr = instr_q;
    assign pc    = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Single-issue instruction fetch stage.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   imem_addr        : byte address to instruction memory (equals the PC)
//   imem_data        : combinational read data for imem_addr
//   redirect_valid   : branch/jump redirect request
//   redirect_pc      : redirect target byte address (must be word aligned)
//   out_valid/ready  : handshake with decode
//   out_instr/out_pc : fetched instruction and its byte address
//   fault            : misaligned redirect seen; fetch stopped until reset
//   fetch_count      : number of instructions handed to decode (wraps)
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned BIT_WIDTH   = 32,
    parameter int unsigned ENTRY_COUNT = 256,
    parameter int unsigned ADDR_WIDTH  = $clog2((BIT_WIDTH / 8) * ENTRY_COUNT),
    parameter int unsigned RESET_PC    = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [BIT_WIDTH-1:0]  imem_data,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BIT_WIDTH-1:0]  out_instr,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic                  fault,
    output logic [31:0]           fetch_count
);

    fetch_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [31:0]           fetch_count_q, fetch_count_d;

    logic load, hold, flush;
    logic advance, redirect_aligned, handshake;

    assign advance          = !out_valid || out_ready;
    assign redirect_aligned = (redirect_pc[1:0] == 2'b00);
    assign handshake        = out_valid && out_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StBoot;
            pc_q          <= ADDR_WIDTH'(RESET_PC);
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    // Next-state logic; boot lasts a single cycle and fault is sticky.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StBoot:  state_d = StRun;
            StRun:   if (redirect_valid && !redirect_aligned) state_d = StFault;
            StFault: state_d = StFault;
            default: state_d = StBoot;
        endcase
    end

    // Output / datapath control. Redirect beats both advance and stall.
    always_comb begin
        load  = 1'b0;
        hold  = 1'b0;
        flush = 1'b0;
        pc_d  = pc_q;
        unique case (state_q)
            StRun: begin
                if (redirect_valid) begin
                    flush = 1'b1;
                    if (redirect_aligned) pc_d = redirect_pc;
                end else if (advance) begin
                    load = 1'b1;
                    // Natural wrap modulo 2^ADDR_WIDTH.
                    pc_d = pc_q + ADDR_WIDTH'(PC_STEP);
                end else begin
                    hold = 1'b1;
                end
            end
            default: begin
                load  = 1'b0;
                hold  = 1'b0;
                flush = 1'b0;
            end
        endcase
    end

    // Out-valid is zero outside RUN, so counting needs no state qualifier.
    always_comb begin
        fetch_count_d = fetch_count_q;
        if (handshake) fetch_count_d = fetch_count_q + 32'd1;
    end

    fetch_out_reg #(
        .BIT_WIDTH (BIT_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_out_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .hold    (hold),
        .flush   (flush),
        .in_instr(imem_data),
        .in_pc   (pc_q),
        .valid   (out_valid),
        .instr   (out_instr),
        .pc      (out_pc)
    );

    assign imem_addr   = pc_q;
    assign fault       = (state_q == StFault);
    assign fetch_count = fetch_count_q;

endmodule
